// File: rtl/i2s_stereo_codec_if_if.sv
// Bus bundle between the I2S master port and its neighbours (codec config, DSP chain, codec pins).
// The master modport is the serial port itself; the slave modport is everything around it.
interface i2s_stereo_codec_if_if #(
  parameter int DATA_W = 24
);
  logic              en;
  logic              mode;
  logic [DATA_W-1:0] dac_l;
  logic [DATA_W-1:0] dac_r;
  logic              dac_valid;
  logic              clr_underrun;
  logic              adc_dat;
  logic              bclk;
  logic              lrck;
  logic              dac_dat;
  logic              sample_tick;
  logic [DATA_W-1:0] adc_l;
  logic [DATA_W-1:0] adc_r;
  logic              adc_valid;
  logic              underrun;
  logic              busy;

  modport master (
    input  en, mode, dac_l, dac_r, dac_valid, clr_underrun, adc_dat,
    output bclk, lrck, dac_dat, sample_tick, adc_l, adc_r, adc_valid, underrun, busy
  );

  modport slave (
    output en, mode, dac_l, dac_r, dac_valid, clr_underrun, adc_dat,
    input  bclk, lrck, dac_dat, sample_tick, adc_l, adc_r, adc_valid, underrun, busy
  );
endinterface

// File: rtl/i2s_stereo_codec_if.sv
// Stereo I2S / left-justified master serial port: BCLK/LRCK generation, DAC serialiser with
// valid handshake and sticky underrun, dual-channel ADC deserialiser, per-frame sample tick.
module i2s_stereo_codec_if #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 25,
  parameter int BCLK_LO = 2,
  parameter int BCLK_HI = 3
) (
  input logic                   clk,
  input logic                   rst,
  i2s_stereo_codec_if_if.master bus
);
  localparam int PER   = BCLK_LO + BCLK_HI;
  localparam int PH_W  = $clog2(PER);
  localparam int BIT_W = $clog2(SLOT_W);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(PER - 1);
  localparam logic [PH_W-1:0]  PH_LO     = PH_W'(BCLK_LO);
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(BCLK_LO + 1);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] DW_B      = BIT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [PH_W-1:0]   ph_reg;
  logic [BIT_W-1:0]  bit_reg;
  logic              ch_reg;
  logic              slot_last;
  logic              frame_last;
  logic              sample_tick;
  logic              busy;

  logic [DATA_W-1:0] dac_l_reg, dac_r_reg;
  logic              mode_reg;
  logic              underrun_reg;
  logic              bclk_reg, lrck_reg, dac_dat_reg;

  logic              data_pos;
  logic [BIT_W-1:0]  idx_full;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word;
  logic              dac_bit;

  logic [DATA_W-1:0] adc_sh_reg, adc_hold_l_reg;
  logic [DATA_W-1:0] adc_l_reg, adc_r_reg;
  logic              adc_valid_reg;

  assign slot_last  = (bit_reg == BIT_MAX) && (ph_reg == PH_MAX);
  assign frame_last = (state_reg == RUN) && ch_reg && slot_last;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.en) state_next = START;
      START:   state_next = RUN;
      RUN:     if (frame_last && !bus.en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sample_tick = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      START: begin
        sample_tick = 1'b1;
        busy        = 1'b1;
      end
      RUN: begin
        sample_tick = frame_last;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase / bit / channel counters; START primes them so RUN begins on left bit 0, phase 0.
  always_ff @(posedge clk) begin
    if (rst || state_reg != RUN) begin
      ph_reg  <= '0;
      bit_reg <= '0;
      ch_reg  <= 1'b0;
    end else if (ph_reg == PH_MAX) begin
      ph_reg <= '0;
      if (bit_reg == BIT_MAX) begin
        bit_reg <= '0;
        ch_reg  <= ~ch_reg;
      end else begin
        bit_reg <= bit_reg + 1'b1;
      end
    end else begin
      ph_reg <= ph_reg + 1'b1;
    end
  end

  // Slot bit -> data bit mapping, shared by the DAC serialiser and the ADC sampler.
  always_comb begin
    if (mode_reg) begin
      data_pos = (bit_reg < DW_B);
      idx_full = DW_B - 1'b1 - bit_reg;
    end else begin
      data_pos = (bit_reg != '0) && (bit_reg <= DW_B);
      idx_full = DW_B - bit_reg;
    end
    idx     = data_pos ? IDX_W'(idx_full) : '0;
    word    = ch_reg ? dac_r_reg : dac_l_reg;
    dac_bit = data_pos & word[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_reg    <= 1'b1;
      lrck_reg    <= 1'b0;
      dac_dat_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      bclk_reg    <= (ph_reg >= PH_LO);
      lrck_reg    <= ~ch_reg;
      dac_dat_reg <= dac_bit;
    end else begin
      bclk_reg    <= 1'b1;
      lrck_reg    <= 1'b0;
      dac_dat_reg <= 1'b0;
    end
  end

  // Tick-time capture: a missing pair keeps the old words so the codec hears a repeat, not silence.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_l_reg    <= '0;
      dac_r_reg    <= '0;
      mode_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (sample_tick) begin
        mode_reg <= bus.mode;
        if (bus.dac_valid) begin
          dac_l_reg <= bus.dac_l;
          dac_r_reg <= bus.dac_r;
        end
      end
      if (sample_tick && !bus.dac_valid) underrun_reg <= 1'b1;
      else if (bus.clr_underrun)         underrun_reg <= 1'b0;
    end
  end

  // ADC: shift in mid-high; left word parked at end of left slot, both published after the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_sh_reg     <= '0;
      adc_hold_l_reg <= '0;
      adc_l_reg      <= '0;
      adc_r_reg      <= '0;
      adc_valid_reg  <= 1'b0;
    end else begin
      adc_valid_reg <= 1'b0;
      if (state_reg == RUN && ph_reg == PH_SAMPLE && data_pos)
        adc_sh_reg <= {adc_sh_reg[DATA_W-2:0], bus.adc_dat};
      if (state_reg == RUN && !ch_reg && slot_last)
        adc_hold_l_reg <= adc_sh_reg;
      if (frame_last) begin
        adc_l_reg     <= adc_hold_l_reg;
        adc_r_reg     <= adc_sh_reg;
        adc_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.bclk        = bclk_reg;
  assign bus.lrck        = lrck_reg;
  assign bus.dac_dat     = dac_dat_reg;
  assign bus.sample_tick = sample_tick;
  assign bus.adc_l       = adc_l_reg;
  assign bus.adc_r       = adc_r_reg;
  assign bus.adc_valid   = adc_valid_reg;
  assign bus.underrun    = underrun_reg;
  assign bus.busy        = busy;
endmodule

// File: tb/tb_i2s_stereo_codec_if.sv
// Directed bench for the I2S master port: framing, I2S/LJ slot contents, ADC loopback,
// underrun handshake, reset abort and graceful stop.
module tb_i2s_stereo_codec_if;
  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_stereo_codec_if_if #(.DATA_W(24)) bus ();

  i2s_stereo_codec_if #(
    .DATA_W(24), .SLOT_W(25), .BCLK_LO(2), .BCLK_HI(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  assign bus.adc_dat = bus.dac_dat;

  // Slot decoder: one bit per BCLK rising edge, 25 bits per slot, keyed by LRCK.
  logic        prev_bclk = 1'b1;
  logic        slot_lr   = 1'b0;
  logic [24:0] slot_sh   = '0;
  logic [24:0] slot_l    = '0;
  logic [24:0] slot_r    = '0;
  int          cnt       = 0;
  int          ticks     = 0;
  int          adc_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_bclk <= 1'b1;
      slot_lr   <= 1'b0;
      cnt       <= 0;
    end else begin
      prev_bclk <= bus.bclk;
      if (bus.bclk && !prev_bclk) begin
        slot_lr <= bus.lrck;
        slot_sh <= {slot_sh[23:0], bus.dac_dat};
        if (bus.lrck != slot_lr) begin
          cnt <= 1;
        end else if (cnt == 24) begin
          cnt <= 0;
          if (bus.lrck) slot_l <= {slot_sh[23:0], bus.dac_dat};
          else          slot_r <= {slot_sh[23:0], bus.dac_dat};
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
    if (bus.sample_tick) ticks <= ticks + 1;
    if (bus.adc_valid)   adc_pulses <= adc_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bclk"},  bus.bclk, 1);
    chk({tag, "_lrck"},  bus.lrck, 0);
    chk({tag, "_dac"},   bus.dac_dat, 0);
    chk({tag, "_tick"},  bus.sample_tick, 0);
    chk({tag, "_avld"},  bus.adc_valid, 0);
    chk({tag, "_undr"},  bus.underrun, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_adcl"},  bus.adc_l, 0);
    chk({tag, "_adcr"},  bus.adc_r, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0;
    int          t1;
    logic        found;
    logic [9:0]  pat;

    rst              = 1'b1;
    bus.en           = 1'b0;
    bus.mode         = 1'b0;
    bus.dac_l        = 24'hA5A5A5;
    bus.dac_r        = 24'h5A5A5A;
    bus.dac_valid    = 1'b1;
    bus.clr_underrun = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");

    // Start streaming in I2S
    rst    = 1'b0;
    bus.en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (bus.sample_tick) found = 1'b1;
    end
    chk("start_tick", found, 1);
    t0 = cyc;
    chk("start_busy", bus.busy, 1);
    goto(t0 + 1);
    chk("start_bclk", bus.bclk, 1);
    goto(t0 + 2);
    chk("lrck_rise", bus.lrck, 1);
    pat = 10'b0011100111;
    for (int i = 0; i < 10; i++) begin
      goto(t0 + 2 + i);
      chk("bclk_pat", bus.bclk, pat[9-i]);
    end
    goto(t0 + 126);  chk("lrck_hi_end", bus.lrck, 1);
    goto(t0 + 127);  chk("lrck_lo_beg", bus.lrck, 0);
    goto(t0 + 249);  chk("no_early_tick", bus.sample_tick, 0);
    goto(t0 + 250);
    chk("tick_250", bus.sample_tick, 1);
    chk("i2s_slot_l", slot_l, 25'h0A5A5A5);
    chk("i2s_slot_r", slot_r, 25'h05A5A5A);
    goto(t0 + 251);
    chk("adc_vld1", bus.adc_valid, 1);
    chk("adc_l1", bus.adc_l, 24'hA5A5A5);
    chk("adc_r1", bus.adc_r, 24'h5A5A5A);
    chk("lrck_frame_end", bus.lrck, 0);
    goto(t0 + 252);
    chk("adc_vld_pulse", bus.adc_valid, 0);
    chk("lrck_frame2", bus.lrck, 1);

    // Mode switched mid-frame: frame 2 stays I2S, frame 3 goes LJ
    goto(t0 + 300);  bus.mode = 1'b1;
    goto(t0 + 500);
    chk("tick_500", bus.sample_tick, 1);
    chk("i2s_hold_slot_l", slot_l, 25'h0A5A5A5);
    chk("i2s_hold_slot_r", slot_r, 25'h05A5A5A);
    goto(t0 + 501);
    chk("adc_l2", bus.adc_l, 24'hA5A5A5);
    chk("adc_r2", bus.adc_r, 24'h5A5A5A);
    goto(t0 + 600);
    bus.dac_l = 24'h123456;
    bus.dac_r = 24'hFEDCBA;
    goto(t0 + 750);
    chk("lj_slot_l", slot_l, 25'h14B4B4A);
    chk("lj_slot_r", slot_r, 25'h0B4B4B4);
    goto(t0 + 751);
    chk("adc_vld3", bus.adc_valid, 1);
    chk("adc_l3", bus.adc_l, 24'hA5A5A5);
    chk("adc_r3", bus.adc_r, 24'h5A5A5A);

    // Underrun at the T0+1000 tick
    goto(t0 + 900);
    bus.dac_valid = 1'b0;
    bus.dac_l     = 24'h111111;
    bus.dac_r     = 24'h222222;
    goto(t0 + 1000);
    chk("undr_before", bus.underrun, 0);
    chk("lj_slot_l4", slot_l, 25'h02468AC);
    chk("lj_slot_r4", slot_r, 25'h1FDB974);
    goto(t0 + 1001);
    chk("undr_set", bus.underrun, 1);
    chk("adc_l4", bus.adc_l, 24'h123456);
    chk("adc_r4", bus.adc_r, 24'hFEDCBA);
    goto(t0 + 1100);
    chk("undr_sticky", bus.underrun, 1);
    bus.clr_underrun = 1'b1;
    goto(t0 + 1101);
    bus.clr_underrun = 1'b0;
    chk("undr_clr", bus.underrun, 0);
    goto(t0 + 1250);
    bus.clr_underrun = 1'b1;
    chk("repeat_slot_l", slot_l, 25'h02468AC);
    chk("repeat_slot_r", slot_r, 25'h1FDB974);
    goto(t0 + 1251);
    bus.clr_underrun = 1'b0;
    chk("undr_set_wins", bus.underrun, 1);
    chk("adc_l5_repeat", bus.adc_l, 24'h123456);
    chk("adc_r5_repeat", bus.adc_r, 24'hFEDCBA);
    goto(t0 + 1252);
    chk("undr_after_clr", bus.underrun, 1);
    chk("tick_count", ticks, 6);
    chk("adc_pulse_count", adc_pulses, 5);

    // Reset in the middle of the right slot
    goto(t0 + 1300);
    bus.dac_valid = 1'b1;
    bus.dac_l     = 24'h0F0F0F;
    bus.dac_r     = 24'hF0F0F0;
    bus.mode      = 1'b0;
    goto(t0 + 1400);
    chk("pre_rst_right", bus.lrck, 0);
    rst = 1'b1;
    goto(t0 + 1401);
    chk_reset_vals("midrst");
    rst    = 1'b0;
    bus.en = 1'b0;
    goto(t0 + 1700);
    chk("no_partial_adc", adc_pulses, 5);
    chk("idle_busy", bus.busy, 0);
    chk("idle_bclk", bus.bclk, 1);

    // Enable drop mid-frame finishes the frame
    bus.en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (bus.sample_tick) found = 1'b1;
    end
    chk("restart_tick", found, 1);
    t1 = cyc;
    goto(t1 + 100);  bus.en = 1'b0;
    goto(t1 + 250);
    chk("stop_busy_last", bus.busy, 1);
    chk("stop_tick", bus.sample_tick, 1);
    goto(t1 + 251);
    chk("stop_busy_off", bus.busy, 0);
    chk("stop_adc_vld", bus.adc_valid, 1);
    chk("stop_adc_l", bus.adc_l, 24'h0F0F0F);
    chk("stop_adc_r", bus.adc_r, 24'hF0F0F0);
    goto(t1 + 300);
    chk("stopped_busy", bus.busy, 0);
    chk("stopped_lrck", bus.lrck, 0);
    chk("stopped_adc_hold", bus.adc_l, 24'h0F0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
